// File: rtl/trap_dispatch_ctrl.sv
// Trap dispatch controller: prioritises exception/interrupt events, latches one
// winner with cause/EPC and hands it to the CSR trap sequencer via req/ack/done.
module trap_dispatch_ctrl #(
  parameter logic [31:0] CAUSE_IRQ = 32'h8000000B,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             illegal_inst,
  input  logic             ecall_m,
  input  logic             l_access_fault,
  input  logic             s_access_fault,
  input  logic             mret,
  input  logic             interrupt,
  input  logic             mstatus_mie,
  input  logic [31:0]      epc_cur,
  input  logic [31:0]      epc_next,
  input  logic             trap_ack,
  input  logic             trap_done,
  output logic             trap_req,
  output logic             trap_is_mret,
  output logic [31:0]      trap_cause,
  output logic [31:0]      trap_epc,
  output logic             stall,
  output logic             irq_pending,
  output logic [CNT_W-1:0] trap_count
);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_e;

  state_e           state_q, state_d;
  logic             irq_pending_q, irq_pending_d;
  logic [31:0]      cause_q, cause_d;
  logic [31:0]      epc_q, epc_d;
  logic             is_mret_q, is_mret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        sync_evt;
  logic        irq_win;
  logic        win_valid;
  logic [31:0] win_cause;
  logic [31:0] win_epc;
  logic        win_mret;

  // Winner selection: synchronous events (incl. mret) always beat the interrupt,
  // and the interrupt may bypass the pending latch in the cycle it arrives.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    win_cause = 32'd0;
    win_epc   = epc_cur;
    win_mret  = 1'b0;
    sync_evt  = illegal_inst | ecall_m | l_access_fault | s_access_fault | mret;
    irq_win   = mstatus_mie & (interrupt | irq_pending_q) & ~sync_evt;
    win_valid = (state_q == IDLE) & (sync_evt | irq_win);
    if (illegal_inst)        win_cause = 32'd2;
    else if (ecall_m)        win_cause = 32'd11;
    else if (l_access_fault) win_cause = 32'd5;
    else if (s_access_fault) win_cause = 32'd7;
    else if (mret)           win_mret  = 1'b1;
    else begin
      win_cause = CAUSE_IRQ;
      win_epc   = epc_next;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      state_q       <= IDLE;
      irq_pending_q <= 1'b0;
      cause_q       <= 32'd0;
      epc_q         <= 32'd0;
      is_mret_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      irq_pending_q <= irq_pending_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      is_mret_q     <= is_mret_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    irq_pending_d = (irq_pending_q | interrupt) & ~((state_q == IDLE) & irq_win);
    cause_d       = cause_q;
    epc_d         = epc_q;
    is_mret_d     = is_mret_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: if (win_valid) state_d = REQ;
      REQ:  if (trap_ack) begin
        state_d = BUSY;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      BUSY: if (trap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Payload is frozen for the whole REQ/BUSY window and reads zero in IDLE.
    if (win_valid) begin
      cause_d   = win_cause;
      epc_d     = win_epc;
      is_mret_d = win_mret;
    end else if (state_d == IDLE) begin
      cause_d   = 32'd0;
      epc_d     = 32'd0;
      is_mret_d = 1'b0;
    end
  end

  always_comb begin
    trap_req     = (state_q == REQ);
    stall        = (state_q != IDLE);
    trap_cause   = cause_q;
    trap_epc     = epc_q;
    trap_is_mret = is_mret_q;
    irq_pending  = irq_pending_q;
    trap_count   = cnt_q;
  end

endmodule

// File: tb/tb_trap_dispatch_ctrl.sv
// Directed bench for trap_dispatch_ctrl: expected traps are queued as stimulus
// is driven and compared by a monitor when each trap_req is first presented.
module tb_trap_dispatch_ctrl;

  localparam logic [31:0] IRQ   = 32'h8000000B;
  localparam int          CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  typedef struct {
    logic [31:0] cause;
    logic [31:0] epc;
    logic        is_mret;
  } trap_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          illegal_inst, ecall_m, l_access_fault, s_access_fault, mret;
  logic          interrupt, mstatus_mie;
  logic [31:0]   epc_cur, epc_next;
  logic          trap_ack, trap_done;
  logic          trap_req, trap_is_mret, stall, irq_pending;
  logic [31:0]   trap_cause, trap_epc;
  logic [CW-1:0] trap_count;

  trap_t sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_cnt  = 0;
  logic  prev_req = 1'b0;

  trap_dispatch_ctrl #(.CAUSE_IRQ(IRQ), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .illegal_inst(illegal_inst), .ecall_m(ecall_m),
    .l_access_fault(l_access_fault), .s_access_fault(s_access_fault),
    .mret(mret), .interrupt(interrupt), .mstatus_mie(mstatus_mie),
    .epc_cur(epc_cur), .epc_next(epc_next),
    .trap_ack(trap_ack), .trap_done(trap_done),
    .trap_req(trap_req), .trap_is_mret(trap_is_mret),
    .trap_cause(trap_cause), .trap_epc(trap_epc),
    .stall(stall), .irq_pending(irq_pending), .trap_count(trap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] cause, input logic [31:0] epc, input logic m);
    trap_t t;
    t.cause   = cause;
    t.epc     = epc;
    t.is_mret = m;
    sb_q.push_back(t);
  endtask

  task automatic clear_events();
    illegal_inst = 0; ecall_m = 0; l_access_fault = 0;
    s_access_fault = 0; mret = 0; interrupt = 0;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!trap_req && k < 20) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, trap_req}, 32'd1);
  endtask

  task automatic ack_done();
    trap_ack = 1; tick(); trap_ack = 0;
    exp_cnt = (exp_cnt == CMAX) ? CMAX : exp_cnt + 1;
    trap_done = 1; tick(); trap_done = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, trap_req}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_mret"},  {31'd0, trap_is_mret}, 32'd0);
    chk({tag, "_cause"}, trap_cause, 32'd0);
    chk({tag, "_epc"},   trap_epc, 32'd0);
    chk({tag, "_pend"},  {31'd0, irq_pending}, 32'd0);
    chk({tag, "_cnt"},   {28'd0, trap_count}, 32'd0);
  endtask

  // Scoreboard monitor: compare the payload on the first cycle of each request.
  always @(negedge clk) begin
    if (rst) prev_req = 1'b0;
    else begin
      if (trap_req && !prev_req) begin
        if (sb_q.size() == 0) chk("sb_unexpected_trap", trap_cause, 32'hFFFFFFFF);
        else begin
          trap_t t;
          t = sb_q.pop_front();
          chk("sb_cause", trap_cause, t.cause);
          chk("sb_epc", trap_epc, t.epc);
          chk("sb_is_mret", {31'd0, trap_is_mret}, {31'd0, t.is_mret});
        end
      end
      prev_req = trap_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; clear_events(); mstatus_mie = 0;
    epc_cur = 0; epc_next = 0; trap_ack = 0; trap_done = 0;
    repeat (3) tick();
    rst = 0;
    chk_reset_outputs("reset");

    // ecall with handshake and counter
    tick();
    ecall_m = 1; epc_cur = 32'h40; push(32'd11, 32'h40, 1'b0);
    tick(); clear_events();
    chk("ecall_req", {31'd0, trap_req}, 32'd1);
    chk("ecall_stall", {31'd0, stall}, 32'd1);
    chk("ecall_cause", trap_cause, 32'd11);
    chk("ecall_epc", trap_epc, 32'h40);
    trap_ack = 1; tick(); trap_ack = 0; exp_cnt = 1;
    chk("ecall_busy_req", {31'd0, trap_req}, 32'd0);
    chk("ecall_busy_stall", {31'd0, stall}, 32'd1);
    tick();
    trap_done = 1; tick(); trap_done = 0;
    chk("ecall_idle_stall", {31'd0, stall}, 32'd0);
    chk("ecall_idle_cause", trap_cause, 32'd0);
    chk("ecall_cnt", {28'd0, trap_count}, 32'd1);

    // simultaneous synchronous events: only illegal_inst is dispatched
    illegal_inst = 1; l_access_fault = 1; mret = 1; epc_cur = 32'h100;
    push(32'd2, 32'h100, 1'b0);
    tick(); clear_events();
    chk("multi_cause", trap_cause, 32'd2);
    chk("multi_mret", {31'd0, trap_is_mret}, 32'd0);
    ack_done();
    repeat (3) tick();
    chk("multi_no_second", {31'd0, stall}, 32'd0);

    // mret alone
    mret = 1; epc_cur = 32'h180; push(32'd0, 32'h180, 1'b1);
    tick(); clear_events();
    chk("mret_flag", {31'd0, trap_is_mret}, 32'd1);
    ack_done();
    chk("mret_idle_flag", {31'd0, trap_is_mret}, 32'd0);

    // interrupt held pending while mie=0, dispatched once mie rises
    interrupt = 1; tick(); clear_events();
    chk("irq_masked_pend", {31'd0, irq_pending}, 32'd1);
    chk("irq_masked_req", {31'd0, trap_req}, 32'd0);
    tick();
    chk("irq_masked_hold", {31'd0, irq_pending}, 32'd1);
    mstatus_mie = 1; epc_next = 32'h2000; push(IRQ, 32'h2000, 1'b0);
    tick();
    chk("irq_unmask_req", {31'd0, trap_req}, 32'd1);
    chk("irq_unmask_cause", trap_cause, IRQ);
    chk("irq_unmask_pend", {31'd0, irq_pending}, 32'd0);
    ack_done();

    // bypass: interrupt in IDLE with mie=1 goes straight to REQ
    interrupt = 1; epc_next = 32'h3000; push(IRQ, 32'h3000, 1'b0);
    tick(); clear_events();
    chk("bypass_req", {31'd0, trap_req}, 32'd1);
    chk("bypass_pend", {31'd0, irq_pending}, 32'd0);
    ack_done();

    // interrupt with store fault: fault first, interrupt afterwards
    interrupt = 1; s_access_fault = 1; epc_cur = 32'h500; epc_next = 32'h504;
    push(32'd7, 32'h500, 1'b0); push(IRQ, 32'h600, 1'b0);
    tick(); clear_events(); epc_next = 32'h600;
    chk("irqsf_cause", trap_cause, 32'd7);
    chk("irqsf_pend", {31'd0, irq_pending}, 32'd1);
    ack_done();
    wait_req("irqsf_second_req");
    chk("irqsf_second_cause", trap_cause, IRQ);
    chk("irqsf_second_epc", trap_epc, 32'h600);
    chk("irqsf_second_pend", {31'd0, irq_pending}, 32'd0);
    ack_done();

    // ack withheld: payload stable, trap_done in REQ ignored
    l_access_fault = 1; epc_cur = 32'h700; push(32'd5, 32'h700, 1'b0);
    tick(); clear_events(); epc_cur = 32'hDEAD; epc_next = 32'hBEEF;
    trap_done = 1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_req", {31'd0, trap_req}, 32'd1);
      chk("hold_cause", trap_cause, 32'd5);
      chk("hold_epc", trap_epc, 32'h700);
      tick();
    end
    trap_done = 0;
    chk("hold_after_done", {31'd0, trap_req}, 32'd1);
    ack_done();
    chk("hold_cnt", {28'd0, trap_count}, exp_cnt);

    // spurious ack in IDLE
    trap_ack = 1; tick(); trap_ack = 0;
    chk("spur_ack_stall", {31'd0, stall}, 32'd0);
    chk("spur_ack_cnt", {28'd0, trap_count}, exp_cnt);

    // reset mid-BUSY with a pending interrupt
    mstatus_mie = 0; ecall_m = 1; interrupt = 1; epc_cur = 32'h800;
    push(32'd11, 32'h800, 1'b0);
    tick(); clear_events();
    trap_ack = 1; tick(); trap_ack = 0;
    chk("rstbusy_pend", {31'd0, irq_pending}, 32'd1);
    chk("rstbusy_stall", {31'd0, stall}, 32'd1);
    rst = 1; tick(); rst = 0; exp_cnt = 0;
    chk_reset_outputs("rstbusy");
    trap_done = 1; tick(); trap_done = 0;
    chk("rstbusy_done_stall", {31'd0, stall}, 32'd0);
    mstatus_mie = 1;
    repeat (3) tick();
    chk("rstbusy_irq_dropped", {31'd0, stall}, 32'd0);

    // counter saturation
    for (int i = 0; i < CMAX + 3; i++) begin
      ecall_m = 1; epc_cur = 32'h900 + i; push(32'd11, 32'h900 + i, 1'b0);
      tick(); clear_events();
      ack_done();
      chk("sat_cnt", {28'd0, trap_count}, exp_cnt);
    end
    chk("sat_final", {28'd0, trap_count}, CMAX);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_dispatch_ctrl.md
# trap_dispatch_ctrl

Trap dispatch controller sitting between the pipeline's exception/interrupt sources and the CSR trap sequencer. Each cycle it prioritises the raw trap events, latches exactly one winner with its cause code and EPC, and hands it to the sequencer over a req/ack/done handshake. It holds the pipeline while a trap is in flight and keeps asynchronous interrupt pulses pending until they can be dispatched. A saturating dispatch counter supports debug.

## Interface
Parameters:
- CAUSE_IRQ, 32'h8000000B, mcause value for the external interrupt.
- CNT_W, 16, width of the dispatch counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- illegal_inst  in  1  illegal instruction this cycle.
- ecall_m  in  1  ecall in M-mode this cycle.
- l_access_fault  in  1  load access fault this cycle.
- s_access_fault  in  1  store access fault this cycle.
- mret  in  1  mret retiring this cycle.
- interrupt  in  1  external interrupt pulse, level-sampled.
- mstatus_mie  in  1  global interrupt enable, mstatus[3].
- epc_cur  in  32  PC of the faulting instruction.
- epc_next  in  32  PC of the next instruction to execute.
- trap_ack  in  1  sequencer accepts the presented trap.
- trap_done  in  1  sequencer has finished its CSR writes and redirect.
- trap_req  out  1  a trap is presented.
- trap_is_mret  out  1  the presented trap is an mret.
- trap_cause  out  32  mcause value to write.
- trap_epc  out  32  mepc value to write.
- stall  out  1  freeze fetch/decode while a trap is in flight.
- irq_pending  out  1  interrupt latched but not yet dispatched.
- trap_count  out  CNT_W  number of dispatched traps, saturating.

## Operation
- States: IDLE, REQ, BUSY.
- Event sampling happens in IDLE only. Synchronous events are ignored in REQ and BUSY, because the pipeline is flushed by the sequencer.
- Fixed priority, highest first: illegal_inst (cause 2), ecall_m (11), l_access_fault (5), s_access_fault (7), mret (cause 0, trap_is_mret=1), interrupt (CAUSE_IRQ).
- EPC is epc_cur for all exceptions and mret, and epc_next for an interrupt.
- Interrupt handling:
  - interrupt=1 in any state sets the irq_pending latch.
  - The pending interrupt is dispatched from IDLE only if mstatus_mie=1 and no synchronous event or mret is present that cycle.
  - The latch clears on the cycle the interrupt is latched as winner. It stays set while mstatus_mie=0.
- Transitions:
  - IDLE→REQ: a winner exists. trap_cause, trap_epc and trap_is_mret are registered and stay frozen until the controller returns to IDLE.
  - REQ→BUSY: trap_ack=1. trap_count increments on this edge and saturates at all-ones.
  - BUSY→IDLE: trap_done=1.
- Spurious handshakes: trap_ack outside REQ and trap_done outside BUSY are ignored. trap_done in REQ is ignored, and the controller stays in REQ.
- Outputs:
  - trap_req = (state==REQ).
  - stall = (state!=IDLE).
  - In IDLE, trap_cause, trap_epc and trap_is_mret are 0.

## Timing
- Reset values: state IDLE, trap_req 0, trap_is_mret 0, trap_cause 0, trap_epc 0, stall 0, irq_pending 0, trap_count 0.
- Reset during REQ or BUSY aborts the trap. Any pending interrupt is dropped.
- Latency: an event at cycle N gives trap_req=1 and stall=1 from cycle N+1.
- Handshake:
  - ack may be given in the first REQ cycle; the controller is then in BUSY at N+2.
  - trap_req holds with stable payload until ack, with no timeout.
- done at cycle M returns the controller to IDLE at M+1. A new event at M+1 is sampled normally, so the minimum trap-to-trap spacing is 3 cycles.
- Simultaneous events:
  - Several synchronous events in one cycle: only the highest priority one is dispatched, and the others are discarded.
  - interrupt together with a synchronous event: the interrupt is latched pending and dispatched after BUSY→IDLE if mstatus_mie=1 then.
- irq_pending is registered: it is visible the cycle after the interrupt pulse. An interrupt in IDLE with mie=1 and no other event goes straight to REQ at N+1 (bypass), and irq_pending stays 0.
- trap_count at all-ones plus another ack stays at all-ones.

## Test plan
- Reset, then ecall_m=1 at cycle 5 with epc_cur=0x40 → trap_req=1 at cycle 6 with cause 11, epc 0x40; ack at 6, done at 8 → stall=0 at 9, trap_count=1.
- illegal_inst, l_access_fault and mret together, epc_cur=0x100 → cause 2, trap_is_mret=0; the others are dropped and no second trap follows.
- interrupt pulse with mstatus_mie=0 → irq_pending=1, no trap_req; raise mie → trap_req next cycle with cause 0x8000000B, epc=epc_next, irq_pending back to 0.
- interrupt with s_access_fault same cycle, mie=1 → cause 7 first; after done, the interrupt is dispatched (cause 0x8000000B) without a new pulse.
- trap_ack withheld 10 cycles → trap_req and payload stable for all 10; trap_done asserted during REQ is ignored.
- rst asserted mid-BUSY with irq pending → all outputs at reset values the next cycle; a later trap_done has no effect; drive 2^CNT_W acks → trap_count saturates at all-ones.
